// File: rtl/regfile_writeback_queue_if.sv
// Writeback request/commit bundle between the ALU/load paths, the queue and the register file.
// Optional forwarding lookup signals exist only when WB_FORWARD_EN is defined.
interface regfile_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int NREG = 1 << ADDR_W;

    logic              AluValid_40;
    logic [ADDR_W-1:0] AluReg_40;
    logic [DATA_W-1:0] AluData_40;
    logic              AluReady_40;
    logic              MemValid_40;
    logic [ADDR_W-1:0] MemReg_40;
    logic [DATA_W-1:0] MemData_40;
    logic              MemReady_40;
    logic              RegWrite_40;
    logic [ADDR_W-1:0] WriteRegister_40;
    logic [DATA_W-1:0] WriteData_40;
    logic [NREG-1:0]   Pending_40;
    logic [CW-1:0]     Count_40;
`ifdef WB_FORWARD_EN
    logic [ADDR_W-1:0] FwdReg_40;
    logic              FwdHit_40;
    logic [DATA_W-1:0] FwdData_40;

    modport master (
        output AluValid_40, AluReg_40, AluData_40, MemValid_40, MemReg_40, MemData_40, FwdReg_40,
        input  AluReady_40, MemReady_40, RegWrite_40, WriteRegister_40, WriteData_40,
               Pending_40, Count_40, FwdHit_40, FwdData_40
    );
    modport slave (
        input  AluValid_40, AluReg_40, AluData_40, MemValid_40, MemReg_40, MemData_40, FwdReg_40,
        output AluReady_40, MemReady_40, RegWrite_40, WriteRegister_40, WriteData_40,
               Pending_40, Count_40, FwdHit_40, FwdData_40
    );
`else
    modport master (
        output AluValid_40, AluReg_40, AluData_40, MemValid_40, MemReg_40, MemData_40,
        input  AluReady_40, MemReady_40, RegWrite_40, WriteRegister_40, WriteData_40,
               Pending_40, Count_40
    );
    modport slave (
        input  AluValid_40, AluReg_40, AluData_40, MemValid_40, MemReg_40, MemData_40,
        output AluReady_40, MemReady_40, RegWrite_40, WriteRegister_40, WriteData_40,
               Pending_40, Count_40
    );
`endif
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order writeback FIFO feeding the register file write port; Mem enqueued ahead of ALU.
// Latency: accepted at edge k, committed at edge k+1; drains one entry per cycle, never stalls.
// Backpressure: readies from registered Count_40 (pop not credited); Mem wins the last slot. Option: WB_FORWARD_EN.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic Clk_40,
    input  logic Reset_n_40,
    regfile_writeback_queue_if.slave wb
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] dat_q [DEPTH];
    logic [ADDR_W-1:0] reg_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     free;
    logic [PW-1:0]     alu_slot;
    logic              mem_rdy, alu_rdy;
    logic              mem_push, alu_push, pop;
    logic [NREG-1:0]   pending;

    // Readies are forced low while reset is asserted so nothing is accepted then.
    always_comb begin
        free    = CW'(DEPTH) - count_q;
        mem_rdy = Reset_n_40 && (free >= CW'(1));
        alu_rdy = Reset_n_40 && ((free >= CW'(2)) || ((free == CW'(1)) && !wb.MemValid_40));
    end

    // Writes to r0 complete the handshake but never occupy a slot.
    always_comb begin
        mem_push = wb.MemValid_40 && mem_rdy && (wb.MemReg_40 != '0);
        alu_push = wb.AluValid_40 && alu_rdy && (wb.AluReg_40 != '0);
        pop      = (count_q != '0);
        alu_slot = wr_ptr_q + PW'(mem_push);
        wr_ptr_d = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end

    always_ff @(posedge Clk_40 or negedge Reset_n_40) begin
        if (!Reset_n_40) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked solely by the pointers and count.
    always_ff @(posedge Clk_40) begin
        if (mem_push) begin
            dat_q[wr_ptr_q] <= wb.MemData_40;
            reg_q[wr_ptr_q] <= wb.MemReg_40;
        end
        if (alu_push) begin
            dat_q[alu_slot] <= wb.AluData_40;
            reg_q[alu_slot] <= wb.AluReg_40;
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                pending[reg_q[idx]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    assign wb.AluReady_40      = alu_rdy;
    assign wb.MemReady_40      = mem_rdy;
    assign wb.RegWrite_40      = pop;
    assign wb.WriteRegister_40 = pop ? reg_q[rd_ptr_q] : '0;
    assign wb.WriteData_40     = pop ? dat_q[rd_ptr_q] : '0;
    assign wb.Pending_40       = pending;
    assign wb.Count_40         = count_q;

`ifdef WB_FORWARD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_dat;

    // Scan oldest to youngest so the last match seen is the youngest write.
    always_comb begin
        logic [PW-1:0] fidx;
        fidx    = '0;
        fwd_hit = 1'b0;
        fwd_dat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fidx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (wb.FwdReg_40 != '0) && (reg_q[fidx] == wb.FwdReg_40)) begin
                fwd_hit = 1'b1;
                fwd_dat = dat_q[fidx];
            end
        end
    end

    assign wb.FwdHit_40  = fwd_hit;
    assign wb.FwdData_40 = fwd_dat;
`endif
endmodule
